// File: rtl/cacheline_ctrl.sv
// Request sequencer in front of a single-entry cacheline store: CPU load/store
// handshake, lookup, write-through stores, read-miss refill from backing memory.
module cacheline_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] line_addr,
  output logic [DATA_W-1:0] line_val,
  output logic              line_read,
  output logic              line_write,
  input  logic              line_hit,
  input  logic [DATA_W-1:0] line_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    CHECK  = 3'd2,
    MEM    = 3'd3,
    FILL   = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               hit_q, hit_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Next-state and next latched-request values.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    hit_d   = hit_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          data_d  = '0;
          hit_d   = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK: begin
        if (we_q) begin
          // A refused store still goes through to memory.
          hit_d   = line_hit;
          state_d = MEM;
        end else if (line_hit) begin
          data_d  = line_rdata;
          hit_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = MEM;
        end
      end
      MEM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          if (we_q) begin
            state_d = RESP;
          end else begin
            data_d  = mem_rdata;
            state_d = FILL;
          end
        end else if (cnt_d == CNT_W'(MEM_TIMEOUT)) begin
          err_d   = 1'b1;
          hit_d   = 1'b0;
          data_d  = '0;
          state_d = RESP;
        end
      end
      FILL:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request, and outputs registered from the state being entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      data_q     <= '0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      cpu_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_hit    <= 1'b0;
      rsp_err    <= 1'b0;
      line_addr  <= '0;
      line_val   <= '0;
      line_read  <= 1'b0;
      line_write <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      cpu_ready  <= (state_d == IDLE);
      line_addr  <= addr_d;
      line_val   <= (state_d == FILL) ? data_d : wdata_d;
      line_read  <= (state_d == LOOKUP) && !we_d;
      line_write <= ((state_d == LOOKUP) && we_d) || (state_d == FILL);
      mem_req    <= (state_d == MEM);
      mem_we     <= (state_d == MEM) && we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      rsp_valid  <= (state_d == RESP);
      // Response fields hold between strobes.
      if (state_d == RESP) begin
        rsp_data <= data_d;
        rsp_hit  <= hit_d;
        rsp_err  <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_cacheline_ctrl.sv
// Scoreboard bench for cacheline_ctrl with a behavioural cacheline entry and
// a delay-programmable backing memory.
module tb_cacheline_ctrl;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          cpu_valid = 1'b0;
  logic          cpu_ready;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_hit;
  logic          rsp_err;
  logic [AW-1:0] line_addr;
  logic [DW-1:0] line_val;
  logic          line_read;
  logic          line_write;
  logic          line_hit = 1'b0;
  logic [DW-1:0] line_rdata = '0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata = '0;

  logic resp_ack = 1'b0;
  logic stray_ack = 1'b0;
  assign mem_ack = resp_ack | stray_ack;

  cacheline_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .line_addr(line_addr), .line_val(line_val), .line_read(line_read),
    .line_write(line_write), .line_hit(line_hit), .line_rdata(line_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // lat counts posedges from the accept edge to the edge that captures rsp_valid
  typedef struct {
    logic [DW-1:0] data;
    logic          hit;
    logic          err;
    int            lat;
    int            acc;
  } exp_t;

  exp_t pend_q[$];
  exp_t exp_q[$];

  int n_vec = 0, n_bad = 0;
  int cyc = 0, acc_cnt = 0, lw_cnt = 0, mr_cnt = 0, n_rsp = 0;
  bit armed = 1'b0;
  int ack_delay = 0;
  logic line_refuse = 1'b0;
  logic          cap_we = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic [DW-1:0] cap_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single-entry cacheline: registers hit/data on the read or write edge.
  logic          lv = 1'b0;
  logic [AW-1:0] ltag = '0;
  logic [DW-1:0] lval = '0;
  always @(posedge clock) begin
    if (armed) begin
      if (line_read) begin
        line_hit   <= lv && (ltag == line_addr);
        line_rdata <= lval;
      end else if (line_write) begin
        if (!line_refuse || !lv || (ltag == line_addr)) begin
          lv       <= 1'b1;
          ltag     <= line_addr;
          lval     <= line_val;
          line_hit <= 1'b1;
        end else begin
          line_hit <= 1'b0;
        end
      end
    end
  end

  // Backing memory: acks on MEM cycle ack_delay (0 = never).
  int mcnt = 0;
  always @(negedge clock) begin
    if (mem_req) begin
      mcnt++;
      resp_ack = (ack_delay != 0) && (mcnt == ack_delay);
    end else begin
      mcnt = 0;
      resp_ack = 1'b0;
    end
  end

  // Edge observer: accepts move expectations to the scoreboard with a timestamp.
  always @(posedge clock) begin
    cyc++;
    if (armed && reset_n) begin
      if (line_write) lw_cnt++;
      if (mem_req) mr_cnt++;
      if (mem_req && mem_ack) begin
        cap_we    = mem_we;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
      end
      if (cpu_valid && cpu_ready) begin
        acc_cnt++;
        check("accept_expected", 32'(pend_q.size() != 0), 32'd1);
        if (pend_q.size() != 0) begin
          exp_t e;
          e = pend_q.pop_front();
          e.acc = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Response monitor.
  logic rsp_prev = 1'b0;
  always @(posedge clock) begin
    #1;
    if (armed && reset_n) begin
      if (rsp_prev) check("ready_after_rsp", 32'(cpu_ready), 32'd1);
      rsp_prev = rsp_valid;
      if (rsp_valid) begin
        n_rsp++;
        check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_hit", 32'(rsp_hit), 32'(e.hit));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end else begin
      rsp_prev = 1'b0;
    end
  end

  task automatic expect_rsp(input logic [DW-1:0] d, input logic h, input logic er, input int lat);
    exp_t e;
    e.data = d; e.hit = h; e.err = er; e.lat = lat; e.acc = 0;
    pend_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int target;
    bit ok;
    ok = 1'b0;
    target = acc_cnt + 1;
    @(negedge clock);
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (acc_cnt >= target) begin ok = 1'b1; break; end
    end
    cpu_valid = 1'b0;
    check("accept_in_time", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (pend_q.size() == 0 && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check("drain_in_time", 32'(ok), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_outs_zero"}, 32'(|{rsp_valid, rsp_data, rsp_hit, rsp_err, line_addr,
                                      line_val, line_read, line_write, mem_req, mem_we,
                                      mem_addr, mem_wdata}), 32'd0);
    check({tag, "_ready"}, 32'(cpu_ready), 32'd1);
  endtask

  int lw0, mr0, r0, t0;
  bit seen;

  initial begin
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_outs("reset");
    armed = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Load miss on empty line, ack on MEM cycle 2, one FILL write
    ack_delay = 2; mem_rdata = 32'hDEADBEEF; lw0 = lw_cnt; mr0 = mr_cnt;
    expect_rsp(32'hDEADBEEF, 1'b0, 1'b0, 6);
    issue(1'b0, 8'h12, 32'h0);
    drain();
    check("miss_fill_writes", 32'(lw_cnt - lw0), 32'd1);
    check("miss_mem_cycles", 32'(mr_cnt - mr0), 32'd2);
    check("miss_mem_we", 32'(cap_we), 32'd0);
    check("miss_mem_addr", 32'(cap_addr), 32'h12);

    // Reload hits without touching memory
    lw0 = lw_cnt; mr0 = mr_cnt;
    expect_rsp(32'hDEADBEEF, 1'b1, 1'b0, 3);
    issue(1'b0, 8'h12, 32'h0);
    drain();
    check("hit_mem_cycles", 32'(mr_cnt - mr0), 32'd0);
    check("hit_line_writes", 32'(lw_cnt - lw0), 32'd0);

    // Write-through store accepted by the line
    ack_delay = 1; lw0 = lw_cnt; mr0 = mr_cnt;
    expect_rsp(32'h0, 1'b1, 1'b0, 4);
    issue(1'b1, 8'h34, 32'hCAFEF00D);
    drain();
    check("store_line_writes", 32'(lw_cnt - lw0), 32'd1);
    check("store_mem_cycles", 32'(mr_cnt - mr0), 32'd1);
    check("store_mem_we", 32'(cap_we), 32'd1);
    check("store_mem_addr", 32'(cap_addr), 32'h34);
    check("store_mem_wdata", cap_wdata, 32'hCAFEF00D);

    // Store whose eviction the line refuses still writes memory
    line_refuse = 1'b1; ack_delay = 3;
    expect_rsp(32'h0, 1'b0, 1'b0, 6);
    issue(1'b1, 8'h56, 32'h12345678);
    drain();
    line_refuse = 1'b0;
    check("refused_mem_addr", 32'(cap_addr), 32'h56);
    check("refused_mem_wdata", cap_wdata, 32'h12345678);

    expect_rsp(32'hCAFEF00D, 1'b1, 1'b0, 3);
    issue(1'b0, 8'h34, 32'h0);
    drain();

    // Memory never acks: abort after TMO cycles
    ack_delay = 0; mr0 = mr_cnt;
    expect_rsp(32'h0, 1'b0, 1'b1, 3 + int'(TMO));
    issue(1'b0, 8'h77, 32'h0);
    drain();
    check("timeout_mem_cycles", 32'(mr_cnt - mr0), 32'(TMO));

    // Reset while waiting on memory
    r0 = n_rsp;
    expect_rsp(32'h0, 1'b0, 1'b0, 0);
    issue(1'b0, 8'h99, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    check("mem_req_seen", 32'(seen), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_outs("midmem_reset");
    pend_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("midmem_no_rsp", 32'(n_rsp - r0), 32'd0);
    expect_rsp(32'hCAFEF00D, 1'b1, 1'b0, 3);
    issue(1'b0, 8'h34, 32'h0);
    drain();

    // Stray ack in IDLE, then cpu_valid held across three hit requests
    r0 = n_rsp; mr0 = mr_cnt;
    stray_ack = 1'b1;
    repeat (3) @(negedge clock);
    check("stray_no_rsp", 32'(n_rsp - r0), 32'd0);
    check("stray_ready", 32'(cpu_ready), 32'd1);
    for (int i = 0; i < 3; i++) expect_rsp(32'hCAFEF00D, 1'b1, 1'b0, 3);
    t0 = acc_cnt + 3;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h34; cpu_wdata = '0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (acc_cnt >= t0) begin seen = 1'b1; break; end
    end
    cpu_valid = 1'b0;
    check("held_accepts", 32'(seen), 32'd1);
    drain();
    stray_ack = 1'b0;
    repeat (2) @(negedge clock);
    check("held_rsp_count", 32'(n_rsp - r0), 32'd3);
    check("held_mem_cycles", 32'(mr_cnt - mr0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
